// File: rtl/rx_burst_if.sv
// Sample and symbol streams into the RX burst controller.
//
// Both streams use valid-only semantics: the producer raises sample_valid
// (or pulses demod_symbol_strobe) for exactly the cycles in which the data
// beside it is meaningful, and the consumer takes every valid beat on the
// rising clock edge. There is no ready/backpressure.
interface rx_burst_if #(
    parameter int SAMPLE_BITS = 9
);
    logic                          sample_valid;
    logic signed [SAMPLE_BITS-1:0] rx_inphase;
    logic signed [SAMPLE_BITS-1:0] rx_quadrature;
    logic                          demod_symbol_strobe;
    logic                          demod_symbol;

    modport master (
        output sample_valid, rx_inphase, rx_quadrature,
        output demod_symbol_strobe, demod_symbol
    );

    modport slave (
        input sample_valid, rx_inphase, rx_quadrature,
        input demod_symbol_strobe, demod_symbol
    );
endinterface

// File: rtl/rx_burst.sv
// Receive-side burst controller: detects burst energy from |I|+|Q| averaged
// over a sliding window with on/off hysteresis, aligns a local copy of the
// TX test LFSR to the demodulated bits, then counts bit errors until the
// burst ends.
module rx_burst #(
    parameter int         SAMPLE_BITS   = 9,
    parameter int         AVG_LOG2      = 4,
    parameter logic [7:0] LFSR_TAPS     = 8'h8e,
    parameter logic [7:0] LFSR_SEED     = 8'h01,
    parameter int         SYNC_SYMBOLS  = 8,
    parameter int         BURST_SYMBOLS = 148
) (
    input  logic                 clock,
    input  logic                 reset_n,
    rx_burst_if.slave            rx,
    input  logic [SAMPLE_BITS:0] threshold_on,
    input  logic [SAMPLE_BITS:0] threshold_off,
    output logic [SAMPLE_BITS:0] energy_level,
    output logic                 burst_active,
    output logic                 locked,
    output logic [7:0]           bit_errors,
    output logic [7:0]           symbols_checked,
    output logic                 burst_done,
    output logic                 sync_fail,
    output logic                 debug_pin,
    output logic [1:0]           state_dbg
);
    localparam int MW    = SAMPLE_BITS + 1;
    localparam int AW    = MW + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_TRACK, S_DONE} state_t;

    // Absolute value in one extra bit so that the most negative input
    // (e.g. -256) maps to +256 without wrapping.
    function automatic logic [MW-1:0] abs_ext(input logic signed [SAMPLE_BITS-1:0] v);
        logic signed [MW-1:0] w;
        w = {v[SAMPLE_BITS-1], v};
        return w[MW-1] ? -w : w;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

    logic [MW-1:0]       mag_r;
    logic                mag_v;
    logic [MW-1:0]       win [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_next;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] match_cnt;
    logic [7:0] slip_cnt;

    // Magnitude stage: one register between the sample and the averager.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_r <= '0;
            mag_v <= 1'b0;
        end else begin
            mag_v <= rx.sample_valid;
            if (rx.sample_valid) begin
                mag_r <= abs_ext(rx.rx_inphase) + abs_ext(rx.rx_quadrature);
            end
        end
    end

    // Running sum: add the newest magnitude, drop the one it overwrites.
    always_comb begin
        acc_next = acc + AW'(mag_r) - AW'(win[wr_ptr]);
    end

    // Circular window and averaged energy; frozen while no samples arrive.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            wr_ptr       <= '0;
            acc          <= '0;
            energy_level <= '0;
        end else if (mag_v) begin
            win[wr_ptr]  <= mag_r;
            wr_ptr       <= wr_ptr + 1'b1;
            acc          <= acc_next;
            energy_level <= acc_next[AW-1:AVG_LOG2];
        end
    end

    logic       exp_bit;
    logic       sym_match;
    logic       energy_hi;
    logic       energy_lo;
    logic [7:0] sym_inc;
    logic [7:0] err_inc;
    logic [7:0] sym_after;
    logic       track_end;

    // Decodes shared by the FSM; the count limit sees the symbol arriving
    // this cycle so a strobe coinciding with the end is still counted.
    always_comb begin
        exp_bit   = lfsr[1];
        sym_match = (rx.demod_symbol == exp_bit);
        energy_hi = (energy_level >= threshold_on);
        energy_lo = (energy_level < threshold_off);
        sym_inc   = (symbols_checked == 8'hff) ? symbols_checked : symbols_checked + 8'd1;
        err_inc   = (bit_errors == 8'hff) ? bit_errors : bit_errors + 8'd1;
        sym_after = rx.demod_symbol_strobe ? sym_inc : symbols_checked;
        track_end = energy_lo || (int'(sym_after) >= BURST_SYMBOLS);
    end

    // Burst FSM: IDLE -> SYNC (slip until aligned) -> TRACK (count errors) -> DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            lfsr            <= LFSR_SEED;
            match_cnt       <= '0;
            slip_cnt        <= '0;
            bit_errors      <= '0;
            symbols_checked <= '0;
            burst_done      <= 1'b0;
            sync_fail       <= 1'b0;
            debug_pin       <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            sync_fail  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (energy_hi) begin
                        state           <= S_SYNC;
                        lfsr            <= LFSR_SEED;
                        match_cnt       <= '0;
                        slip_cnt        <= '0;
                        bit_errors      <= '0;
                        symbols_checked <= '0;
                    end
                end
                S_SYNC: begin
                    if (energy_lo) begin
                        state <= S_IDLE;
                    end else if (rx.demod_symbol_strobe) begin
                        debug_pin <= exp_bit;
                        if (sym_match) begin
                            lfsr      <= lfsr_step(lfsr);
                            match_cnt <= match_cnt + 8'd1;
                            if (int'(match_cnt) + 1 >= SYNC_SYMBOLS) begin
                                state <= S_TRACK;
                            end
                        end else begin
                            // Extra step slides the reference one symbol
                            // further ahead relative to the incoming stream.
                            lfsr      <= lfsr_step(lfsr_step(lfsr));
                            match_cnt <= '0;
                            slip_cnt  <= slip_cnt + 8'd1;
                            if (slip_cnt == 8'd254) begin
                                sync_fail <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                end
                S_TRACK: begin
                    if (rx.demod_symbol_strobe) begin
                        debug_pin       <= exp_bit;
                        lfsr            <= lfsr_step(lfsr);
                        symbols_checked <= sym_inc;
                        if (!sym_match) begin
                            bit_errors <= err_inc;
                        end
                    end
                    if (track_end) begin
                        state      <= S_DONE;
                        burst_done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign burst_active = (state != S_IDLE);
    assign locked       = (state == S_TRACK);
    assign state_dbg    = state;
endmodule

// File: tb/tb_rx_burst.sv
// Bench for rx_burst: energy ramp/decay, LFSR acquisition, error counting,
// sync failure and asynchronous reset in the middle of a burst.
module tb_rx_burst;
  localparam int         SB   = 9;
  localparam logic [7:0] TAPS = 8'h8e;
  localparam logic [7:0] SEED = 8'h01;
  localparam int         W    = 17;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [SB:0]   threshold_on;
  logic [SB:0]   threshold_off;
  logic [SB:0]   energy_level;
  logic          burst_active;
  logic          locked;
  logic [7:0]    bit_errors;
  logic [7:0]    symbols_checked;
  logic          burst_done;
  logic          sync_fail;
  logic          debug_pin;
  logic [1:0]    state_dbg;

  rx_burst_if #(.SAMPLE_BITS(SB)) rx_if ();

  rx_burst #(.SAMPLE_BITS(SB)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rx              (rx_if),
    .threshold_on    (threshold_on),
    .threshold_off   (threshold_off),
    .energy_level    (energy_level),
    .burst_active    (burst_active),
    .locked          (locked),
    .bit_errors      (bit_errors),
    .symbols_checked (symbols_checked),
    .burst_done      (burst_done),
    .sync_fail       (sync_fail),
    .debug_pin       (debug_pin),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic        sf_seen = 1'b0;
  logic [7:0]  tx_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? TAPS : 8'h00);
  endfunction

  // driver tasks
  task automatic set_iq(input logic v, input int i, input int q);
    rx_if.sample_valid  = v;
    rx_if.rx_inphase    = SB'(i);
    rx_if.rx_quadrature = SB'(q);
  endtask

  task automatic send_sym(input logic b);
    @(negedge clock);
    rx_if.demod_symbol_strobe = 1'b1;
    rx_if.demod_symbol        = b;
    @(negedge clock);
    rx_if.demod_symbol_strobe = 1'b0;
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    while (state_dbg != 2'd1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("reach_sync", state_dbg, 2'd1);
  endtask

  // Stream is the TX sequence from SEED advanced 5 steps; from a fresh
  // SYNC entry this closes with 5 slips and locks on the 20th symbol.
  task automatic acquire(output logic ok);
    int n;
    tx_l = SEED;
    repeat (5) tx_l = step(tx_l);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 60) begin
      send_sym(tx_l[1]);
      tx_l = step(tx_l);
      n++;
      if (locked) ok = 1'b1;
    end
    check("lock_strobes", n, 20);
    check("locked", locked, 1'b1);
  endtask

  task automatic track(input int count, input int inv0, input int inv1, input int inv2);
    logic b;
    for (int k = 0; k < count; k++) begin
      b = tx_l[1];
      send_sym(b ^ (k == inv0 || k == inv1 || k == inv2));
      check("debug_pin", debug_pin, b);
      tx_l = step(tx_l);
    end
  endtask

  // scoreboard monitor: pops one expectation per burst_done / sync_fail pulse
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(negedge clock);
      if (reset_n && (burst_done || sync_fail)) begin
        got = {sync_fail, bit_errors, symbols_checked};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("event", got, e);
        end
        if (sync_fail) begin
          check("sync_fail_idle", burst_active, 1'b0);
          sf_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    int   exp_e;
    int   prev_e;
    logic ok;
    logic lock_seen;

    set_iq(1'b0, 0, 0);
    rx_if.demod_symbol_strobe = 1'b0;
    rx_if.demod_symbol        = 1'b0;
    threshold_on  = 10'd100;
    threshold_off = 10'd50;
    repeat (3) @(negedge clock);
    check("rst_energy", energy_level, 0);
    check("rst_active", burst_active, 0);
    check("rst_locked", locked, 0);
    check("rst_errors", bit_errors, 0);
    check("rst_syms", symbols_checked, 0);
    check("rst_done_fail_dbg", {burst_done, sync_fail, debug_pin}, 0);
    reset_n = 1'b1;

    // ramp with I=100, Q=-50 (mag 150)
    @(negedge clock);
    set_iq(1'b1, 100, -50);
    prev_e = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      exp_e = (((c - 1) > 16 ? 16 : (c - 1)) * 150) / 16;
      check("ramp_energy", energy_level, exp_e);
      check("ramp_active", burst_active, prev_e >= 100);
      prev_e = exp_e;
    end

    // full-scale negative samples, freeze, then decay
    set_iq(1'b1, -256, -256);
    repeat (18) @(negedge clock);
    check("max_energy", energy_level, 512);
    set_iq(1'b0, 0, 0);
    repeat (5) @(negedge clock);
    check("frozen_energy", energy_level, 512);
    set_iq(1'b1, 0, 0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clock);
      if (c == 9)  check("decay_half", energy_level, 256);
      if (c == 17) check("decay_zero", energy_level, 0);
    end
    @(negedge clock);
    check("decay_idle", burst_active, 0);

    // burst A: clean full-length burst
    set_iq(1'b1, 100, -50);
    wait_sync();
    acquire(ok);
    if (ok) begin
      exp_q.push_back({1'b0, 8'd0, 8'd148});
      track(148, -1, -1, -1);
    end
    repeat (2) @(negedge clock);

    // burst B: three inverted symbols, energy drops after 60 symbols
    wait_sync();
    acquire(ok);
    if (ok) begin
      exp_q.push_back({1'b0, 8'd3, 8'd60});
      track(60, 5, 20, 40);
      set_iq(1'b1, 0, 0);
      for (int n = 0; n < 40 && burst_active; n++) @(negedge clock);
      check("drop_idle", burst_active, 0);
      check("held_errors", bit_errors, 3);
      check("held_syms", symbols_checked, 60);
      repeat (5) @(negedge clock);
      check("held_errors_late", bit_errors, 3);
      check("held_syms_late", symbols_checked, 60);
      check("held_state", state_dbg, 0);
    end

    // all-zero symbols never lock and eventually give up
    set_iq(1'b1, 100, -50);
    wait_sync();
    exp_q.push_back({1'b1, 8'd0, 8'd0});
    sf_seen = 1'b0;
    lock_seen = 1'b0;
    for (int k = 0; k < 2000 && !sf_seen; k++) begin
      send_sym(1'b0);
      if (locked) lock_seen = 1'b1;
    end
    check("sync_fail_seen", sf_seen, 1'b1);
    check("zero_no_lock", lock_seen, 1'b0);
    repeat (2) @(negedge clock);

    // asynchronous reset in the middle of TRACK, then a fresh burst
    wait_sync();
    acquire(ok);
    if (ok) begin
      track(10, -1, -1, -1);
      check("pre_reset_syms", symbols_checked, 10);
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("arst_energy", energy_level, 0);
      check("arst_active", burst_active, 0);
      check("arst_locked", locked, 0);
      check("arst_syms", symbols_checked, 0);
      check("arst_dbg", debug_pin, 0);
      @(negedge clock);
      reset_n = 1'b1;
      wait_sync();
      acquire(ok);
      if (ok) begin
        exp_q.push_back({1'b0, 8'd0, 8'd148});
        track(148, -1, -1, -1);
      end
      repeat (3) @(negedge clock);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rx_burst.md
Name: rx_burst

Overview:
Receive-side burst controller, the counterpart of the GMSK TX burst path. It watches incoming I/Q samples for burst energy using |I|+|Q| averaged over a sliding window with on/off hysteresis. It then aligns a local copy of the TX test LFSR (Galois, taps 8'h8e, output bit lfsr[1]) to the demodulated symbol stream and counts bit errors until the burst ends. It sits between the RX sample chain/demodulator and the debug/status logic.

Parameters:
SAMPLE_BITS, 9, signed width of rx_inphase/rx_quadrature
AVG_LOG2, 4, log2 of moving-average window length (16 samples)
LFSR_TAPS, 8'h8e, Galois feedback taps of the reference LFSR
LFSR_SEED, 8'h01, reference LFSR value after reset and on each SYNC entry
SYNC_SYMBOLS, 8, consecutive matches required to declare lock
BURST_SYMBOLS, 148, symbols checked before forced end of burst

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  rx_inphase/rx_quadrature valid this cycle
rx_inphase  in  SAMPLE_BITS  signed I sample
rx_quadrature  in  SAMPLE_BITS  signed Q sample
demod_symbol_strobe  in  1  one-cycle pulse, demod_symbol valid
demod_symbol  in  1  demodulated hard bit
threshold_on  in  SAMPLE_BITS+1  energy level to start a burst (unsigned)
threshold_off  in  SAMPLE_BITS+1  energy level below which a burst ends (unsigned)
energy_level  out  SAMPLE_BITS+1  averaged |I|+|Q|
burst_active  out  1  high whenever state != IDLE
locked  out  1  high in TRACK
bit_errors  out  8  saturating error count for current/last burst
symbols_checked  out  8  saturating TRACK symbol count
burst_done  out  1  one-cycle pulse when TRACK ends
sync_fail  out  1  one-cycle pulse when SYNC gives up
debug_pin  out  1  registered copy of the expected reference bit

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all outputs 0, moving-average buffer and accumulator 0, ref LFSR=LFSR_SEED.
- Magnitude: on sample_valid, mag = |I|+|Q|, unsigned SAMPLE_BITS+1 bits. |-256| = 256 exactly, no wrap. Registered, 1 cycle.
- Averaging: uses a 2^AVG_LOG2-entry circular buffer of mag. On each registered mag, acc <= acc + mag - oldest and the entry is overwritten. acc width is SAMPLE_BITS+1+AVG_LOG2. energy_level <= acc >> AVG_LOG2. Sample to energy_level latency is 2 cycles. No sample_valid means buffer, acc and energy_level are frozen.
- LFSR step: expected = lfsr[1]. Next lfsr = {1'b0, lfsr[7:1]}, XORed with LFSR_TAPS when lfsr[0]=1.
- FSM, with transitions one cycle after the registered condition:
  - IDLE: when energy_level >= threshold_on, go to SYNC. On entry: lfsr=LFSR_SEED, match_cnt=0, slip_cnt=0, bit_errors=0, symbols_checked=0.
  - SYNC: on each strobe, compare demod_symbol with expected and step the LFSR. On a match, match_cnt++; at SYNC_SYMBOLS go to TRACK. On a mismatch, match_cnt=0, step once more (slip) and slip_cnt++. When slip_cnt reaches 255, pulse sync_fail and go to IDLE. When energy_level < threshold_off, go to IDLE with no pulse.
  - TRACK: on each strobe, compare, step the LFSR and increment symbols_checked. On a mismatch, bit_errors++. Both counters saturate at 255. Go to DONE when energy_level < threshold_off or symbols_checked reaches BURST_SYMBOLS.
  - DONE: pulse burst_done for one cycle, then go to IDLE. bit_errors and symbols_checked hold until the next SYNC entry.
- Simultaneous strobe and end condition in TRACK: the symbol is counted first, then DONE follows.
- Strobe in IDLE or DONE: ignored.
- threshold_off > threshold_on: legal, may chatter. Not guarded.
- debug_pin updates only on strobes in SYNC/TRACK.

Test Plan:
- Constant I=100, Q=-50 valid every cycle, threshold_on=100 -> energy_level ramps to 150 after 16 samples (+2 cycles); burst_active rises the cycle after energy_level >= 100.
- I=-256, Q=-256 steady -> energy_level=512, no overflow; I=Q=0 afterwards -> decays to 0 in 16 samples.
- Energy present; symbols = TX LFSR sequence from seed 8'h01 advanced 5 steps -> locked after 8 matches (5 slips); 148 symbols later burst_done pulses, bit_errors=0, symbols_checked=148.
- Same, with 3 TRACK symbols inverted -> bit_errors=3; energy dropped below threshold_off mid-burst -> burst_done with partial symbols_checked, counts held in IDLE.
- All-zero symbols with energy present -> no lock; sync_fail pulses after 255 slips; state=IDLE.
- reset_n low mid-TRACK (asynchronous, between clock edges) -> all outputs 0 immediately; after release, a fresh burst locks normally.
